// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with a start/done handshake
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             h1_s, h1_c, h2_s, h2_c, fa_c;
    logic [WIDTH-1:0] res_nxt;
    assign h1_s    = a_sr[0] ^ b_sr[0];
    assign h1_c    = a_sr[0] & b_sr[0];
    assign h2_s    = h1_s ^ c;
    assign h2_c    = h1_s & c;
    assign fa_c    = h1_c | h2_c;
    assign res_nxt = {h2_s, res_sr};
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    a_sr      <= a_in;
                    b_sr      <= b_in;
                    c         <= cin_in;
                    cnt       <= '0;
                    state     <= SHIFT;
                    ready_out <= 1'b0;
                    busy_out  <= 1'b1;
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    c      <= fa_c;
                    res_sr <= res_nxt[WIDTH-1:1];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_out   <= res_nxt;
                        carry_out <= fa_c;
                        state     <= DONE;
                        busy_out  <= 1'b0;
                        done_out  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done_out  <= 1'b0;
                    ready_out <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    ready_out <= 1'b1;
                    busy_out  <= 1'b0;
                    done_out  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         ready, busy, done, carry;
    logic [W-1:0] sum;
    int           tests = 0;
    int           fails = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .a_in(a), .b_in(b),
        .cin_in(cin), .ready_out(ready), .busy_out(busy), .done_out(done),
        .sum_out(sum), .carry_out(carry)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         output int lat, output int busy_n, output bit got);
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; busy_n = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            busy_n += int'(busy);
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h want 00", sum); end
        tests++; if (carry !== 1'b0) begin fails++; $display("FAIL reset_carry got %b want 0", carry); end
    endtask

    task automatic test_basic;
        int lat, bn; bit got;
        do_op(8'h3C, 8'h5A, 1'b0, lat, bn, got);
        tests++; if (!got) begin fails++; $display("FAIL basic_done got none want pulse"); end
        tests++; if (lat != 8) begin fails++; $display("FAIL basic_latency got %0d want 8", lat); end
        tests++; if (bn != 8) begin fails++; $display("FAIL basic_busy_cycles got %0d want 8", bn); end
        tests++; if ({carry, sum} !== 9'h096) begin fails++; $display("FAIL basic_sum got %b/%h want 0/96", carry, sum); end
        @(negedge clk);
        tests++; if (done !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL basic_after got done=%b ready=%b want 0/1", done, ready); end
    endtask

    task automatic test_carry;
        logic [W-1:0] xa [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] xb [3] = '{8'h01, 8'hFF, 8'h00};
        logic         xc [3] = '{1'b0, 1'b1, 1'b1};
        logic [W:0]   xe [3] = '{9'h100, 9'h1FF, 9'h001};
        int lat, bn; bit got;
        for (int i = 0; i < 3; i++) begin
            do_op(xa[i], xb[i], xc[i], lat, bn, got);
            tests++;
            if (!got || {carry, sum} !== xe[i]) begin
                fails++;
                $display("FAIL carry_%0d got done=%b %b/%h want %b/%h", i, got, carry, sum, xe[i][W], xe[i][W-1:0]);
            end
        end
    endtask

    task automatic test_random;
        int lat, bn; bit got;
        logic [W-1:0] x, y; logic ci; logic [W:0] e;
        for (int i = 0; i < 24; i++) begin
            x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
            e = model(x, y, ci);
            do_op(x, y, ci, lat, bn, got);
            tests++;
            if (!got || lat != 8 || {carry, sum} !== e) begin
                fails++;
                $display("FAIL random_%0d %h+%h+%b got done=%b lat=%0d %b/%h want 8 %b/%h", i, x, y, ci, got, lat, carry, sum, e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_ignore;
        int ndone = 0; logic [W-1:0] first_sum = '0, prev_sum; logic first_c = 0; bit stable = 1;
        prev_sum = sum;
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && sum !== prev_sum) stable = 0;
            if (k == 3) begin start = 1'b1; a = 8'hAA; b = 8'h99; cin = 1'b1; end
            if (done) begin
                if (ndone == 0) begin first_sum = sum; first_c = carry; end
                ndone++;
                start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b1;
            end
        end
        start = 1'b0;
        tests++; if (ndone != 1) begin fails++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        tests++; if ({first_c, first_sum} !== 9'h033) begin fails++; $display("FAIL ignore_sum got %b/%h want 0/33", first_c, first_sum); end
        tests++; if (!stable) begin fails++; $display("FAIL ignore_sum_stable got change during shift want hold"); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] xa [3] = '{8'h10, 8'h80, 8'h7F};
        logic [W-1:0] xb [3] = '{8'h20, 8'h80, 8'h01};
        logic [W:0]   xe [3] = '{9'h030, 9'h100, 9'h080};
        int t_done [3]; logic [W:0] r [3];
        int nd = 0, idx = 0;
        @(negedge clk);
        start = 1'b1; cin = 1'b0;
        for (int t = 0; t < 50 && nd < 3; t++) begin
            if (nd < 3 && ready && idx < 3) begin a = xa[idx]; b = xb[idx]; idx++; end
            @(negedge clk);
            if (done) begin t_done[nd] = t; r[nd] = {carry, sum}; nd++; end
        end
        start = 1'b0;
        tests++; if (nd != 3) begin fails++; $display("FAIL b2b_count got %0d want 3", nd); end
        for (int i = 0; i < nd; i++) begin
            tests++;
            if (r[i] !== xe[i]) begin fails++; $display("FAIL b2b_sum_%0d got %b/%h want %b/%h", i, r[i][W], r[i][W-1:0], xe[i][W], xe[i][W-1:0]); end
            if (i > 0) begin
                tests++;
                if (t_done[i] - t_done[i-1] != 10) begin fails++; $display("FAIL b2b_spacing_%0d got %0d want 10", i, t_done[i] - t_done[i-1]); end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bn, nd = 0; bit got;
        @(negedge clk);
        a = 8'h55; b = 8'h66; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs got r=%b b=%b d=%b %b/%h want 1 0 0 0/00", ready, busy, done, carry, sum);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            nd += int'(done);
        end
        tests++; if (nd != 0) begin fails++; $display("FAIL midreset_no_done got %0d want 0", nd); end
        do_op(8'h01, 8'h01, 1'b0, lat, bn, got);
        tests++;
        if (!got || lat != 8 || {carry, sum} !== 9'h002) begin
            fails++;
            $display("FAIL midreset_restart got done=%b lat=%0d %b/%h want 8 0/02", got, lat, carry, sum);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_random;
        test_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
